delay_line_ctl: RTL and testbench

Parametrised, runtime-programmable delay line for strobe-plus-data streams. It generalises the fixed 5-cycle start-pulse delay to any width and a maximum depth, with:
- a delay selectable at run time
- clock-enable stall
- flush
- an in-flight counter

It sits between control FSMs and datapath stages that need a start/valid strobe, optionally with payload, aligned to a pipeline of variable depth.

---
 rtl/delay_line_ctl_if.sv | 31 +++
 rtl/delay_line_ctl.sv | 91 +++++++++
 tb/tb_delay_line_ctl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_line_ctl_if.sv
// Stream, control and status bundle for delay_line_ctl.
// The slave modport is the delay line itself; the master modport is whatever drives it.
interface delay_line_ctl_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 16
);
    localparam int DW = $clog2(MAX_DELAY + 1);

    logic             iCe;
    logic             iFlush;
    logic             iDelayLoad;
    logic [DW-1:0]    iDelay;
    logic             iValid;
    logic [WIDTH-1:0] iData;
    logic             oValid;
    logic [WIDTH-1:0] oData;
    logic [DW-1:0]    oDelay;
    logic [DW-1:0]    oCount;
    logic             oDrop;
    logic             oErr;

    modport slave (
        input  iCe, iFlush, iDelayLoad, iDelay, iValid, iData,
        output oValid, oData, oDelay, oCount, oDrop, oErr
    );

    modport master (
        output iCe, iFlush, iDelayLoad, iDelay, iValid, iData,
        input  oValid, oData, oDelay, oCount, oDrop, oErr
    );
endinterface

// File: rtl/delay_line_ctl.sv
// Runtime-programmable strobe+payload delay line with stall, flush and an in-flight counter.
// The output is a registered-stage mux selected by the active delay.
module delay_line_ctl #(
    parameter int WIDTH         = 8,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 5
) (
    input  logic              aclk,
    input  logic              aresetn,
    delay_line_ctl_if.slave   bus
);
    localparam int DW = $clog2(MAX_DELAY + 1);

    logic [MAX_DELAY:1] stage_v;
    logic [WIDTH-1:0]   stage_d [1:MAX_DELAY];
    logic [DW-1:0]      delay_q;
    logic [DW-1:0]      count_q;
    logic               drop_q;
    logic               err_q;

    logic               tap_v;
    logic [WIDTH-1:0]   tap_d;
    logic               delay_legal;
    logic               load_ok;
    logic               load_bad;
    logic               busy;
    logic               clear_v;

    always_comb begin
        tap_v = 1'b0;
        tap_d = '0;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (delay_q == DW'(k)) begin
                tap_v = stage_v[k];
                tap_d = stage_d[k];
            end
        end
    end

    assign delay_legal = (bus.iDelay != '0) && (bus.iDelay <= DW'(MAX_DELAY));
    assign load_ok     = bus.iDelayLoad & delay_legal;
    assign load_bad    = bus.iDelayLoad & ~delay_legal;
    assign busy        = (count_q != '0) | (bus.iCe & bus.iValid);
    // Every legal load clears the valids, even with an empty window: stale strobes parked
    // beyond the old tap would otherwise reappear inside a longer window and corrupt oCount.
    assign clear_v     = load_ok | bus.iFlush;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stage_v <= '0;
            for (int k = 1; k <= MAX_DELAY; k++) begin
                stage_d[k] <= '0;
            end
            delay_q <= DW'(DEFAULT_DELAY);
            count_q <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            drop_q <= load_ok & busy;
            if (load_bad) begin
                err_q <= 1'b1;
            end
            if (load_ok) begin
                delay_q <= bus.iDelay;
            end
            if (bus.iCe) begin
                stage_d[1] <= bus.iData;
                for (int k = 2; k <= MAX_DELAY; k++) begin
                    stage_d[k] <= stage_d[k-1];
                end
            end
            if (clear_v) begin
                stage_v <= '0;
                count_q <= '0;
            end else if (bus.iCe) begin
                stage_v[1] <= bus.iValid;
                for (int k = 2; k <= MAX_DELAY; k++) begin
                    stage_v[k] <= stage_v[k-1];
                end
                count_q <= count_q + DW'(bus.iValid) - DW'(tap_v);
            end
        end
    end

    assign bus.oValid = tap_v;
    assign bus.oData  = tap_d;
    assign bus.oDelay = delay_q;
    assign bus.oCount = count_q;
    assign bus.oDrop  = drop_q;
    assign bus.oErr   = err_q;
endmodule

// File: tb/tb_delay_line_ctl.sv
// Scoreboard bench for delay_line_ctl: accepted strobes are queued with their due enabled edge
// and checked when presented; oCount is checked against the scoreboard occupancy.
module tb_delay_line_ctl;
    logic aclk;
    logic aresetn;

    delay_line_ctl_if #(.WIDTH(8), .MAX_DELAY(16)) bus ();

    delay_line_ctl #(.WIDTH(8), .MAX_DELAY(16), .DEFAULT_DELAY(5)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0] d;
        int         due;
    } item_t;

    item_t      q[$];
    int         ecnt;
    int         bD;
    bit         berr;
    int         total;
    int         bad;

    bit         ev_v;
    logic [7:0] ev_d;
    int         ex_cnt;
    bit         x_drop;
    bit         x_err;
    int         x_dly;
    logic       pv;
    logic [7:0] pd;
    logic [4:0] pc;
    logic       pdrop;
    logic       perr;
    logic [4:0] pdly;

    // One clock cycle: drive, sample pre-edge outputs, advance the model, sample post-edge status.
    task automatic cyc(input bit ce, input bit v, input logic [7:0] d,
                       input bit fl, input bit ld, input logic [4:0] dly);
        int sz;
        bit legal;
        bus.iCe        = ce;
        bus.iValid     = v;
        bus.iData      = d;
        bus.iFlush     = fl;
        bus.iDelayLoad = ld;
        bus.iDelay     = dly;
        pv = bus.oValid;
        pd = bus.oData;
        pc = bus.oCount;
        sz = q.size();
        ex_cnt = sz;
        ev_v = 1'b0;
        ev_d = '0;
        if (ce && sz > 0 && q[0].due == ecnt + 1) begin
            ev_v = 1'b1;
            ev_d = q[0].d;
            void'(q.pop_front());
        end
        legal  = ld && (int'(dly) >= 1) && (int'(dly) <= 16);
        x_drop = legal && (sz != 0 || (v && ce));
        if (ce) ecnt++;
        if (legal) begin
            bD = int'(dly);
            q.delete();
        end else if (fl) begin
            q.delete();
        end else if (ce && v) begin
            q.push_back('{d: d, due: ecnt + bD});
        end
        if (ld && !legal) berr = 1'b1;
        x_err = berr;
        x_dly = bD;
        @(posedge aclk);
        #1;
        pdrop = bus.oDrop;
        perr  = bus.oErr;
        pdly  = bus.oDelay;
        bus.iFlush     = 1'b0;
        bus.iDelayLoad = 1'b0;
    endtask

    task automatic test_reset();
        bus.iCe = 1'b0; bus.iValid = 1'b0; bus.iData = '0;
        bus.iFlush = 1'b0; bus.iDelayLoad = 1'b0; bus.iDelay = '0;
        aresetn = 1'b0;
        q.delete(); ecnt = 0; bD = 5; berr = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        total++;
        if (bus.oValid !== 1'b0 || bus.oData !== 8'h00 || bus.oCount !== 5'd0) begin
            bad++;
            $display("[TB] FAIL reset_stream got v=%b d=%h c=%0d exp v=0 d=00 c=0", bus.oValid, bus.oData, bus.oCount);
        end
        total++;
        if (bus.oDelay !== 5'd5 || bus.oDrop !== 1'b0 || bus.oErr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_status got dly=%0d drop=%b err=%b exp dly=5 drop=0 err=0", bus.oDelay, bus.oDrop, bus.oErr);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 25; i++) begin
            cyc(1'b1, i == 10, 8'h5A, 1'b0, 1'b0, 5'd0);
            total++;
            if (pc !== 5'(ex_cnt)) begin bad++; $display("[TB] FAIL basic_count cyc=%0d got=%0d exp=%0d", i, pc, ex_cnt); end
            total++;
            if (pv !== ev_v || (ev_v && pd !== ev_d)) begin bad++; $display("[TB] FAIL basic_out cyc=%0d got=%b/%h exp=%b/%h", i, pv, pd, ev_v, ev_d); end
            total++;
            if (pdrop !== x_drop || pdly !== 5'(x_dly) || perr !== x_err) begin
                bad++; $display("[TB] FAIL basic_status cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", i, pdrop, pdly, perr, x_drop, x_dly, x_err);
            end
        end
    endtask

    task automatic test_load_burst();
        logic [7:0] dat;
        bit v;
        for (int i = 0; i < 36; i++) begin
            v   = (i >= 2 && i <= 4) || (i >= 12 && i <= 14);
            dat = (i < 10) ? 8'(8'hA1 + i - 2) : 8'(8'hA1 + i - 12);
            cyc(1'b1, v, dat, 1'b0, i == 0 || i == 10, (i == 0) ? 5'd1 : 5'd16);
            total++;
            if (pc !== 5'(ex_cnt)) begin bad++; $display("[TB] FAIL burst_count cyc=%0d got=%0d exp=%0d", i, pc, ex_cnt); end
            total++;
            if (pv !== ev_v || (ev_v && pd !== ev_d)) begin bad++; $display("[TB] FAIL burst_out cyc=%0d got=%b/%h exp=%b/%h", i, pv, pd, ev_v, ev_d); end
            total++;
            if (pdrop !== x_drop || pdly !== 5'(x_dly) || perr !== x_err) begin
                bad++; $display("[TB] FAIL burst_status cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", i, pdrop, pdly, perr, x_drop, x_dly, x_err);
            end
        end
    endtask

    task automatic test_stall();
        bit ce;
        for (int i = 0; i < 14; i++) begin
            ce = !(i == 3 || i == 4);
            cyc(ce, i == 2, 8'h44, 1'b0, i == 0, 5'd4);
            total++;
            if (pc !== 5'(ex_cnt)) begin bad++; $display("[TB] FAIL stall_count cyc=%0d got=%0d exp=%0d", i, pc, ex_cnt); end
            if (ce) begin
                total++;
                if (pv !== ev_v || (ev_v && pd !== ev_d)) begin bad++; $display("[TB] FAIL stall_out cyc=%0d got=%b/%h exp=%b/%h", i, pv, pd, ev_v, ev_d); end
            end
            total++;
            if (pdrop !== x_drop || pdly !== 5'(x_dly) || perr !== x_err) begin
                bad++; $display("[TB] FAIL stall_status cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", i, pdrop, pdly, perr, x_drop, x_dly, x_err);
            end
        end
    endtask

    task automatic test_drop();
        bit v;
        bit ld;
        logic [4:0] dly;
        for (int i = 0; i < 42; i++) begin
            v   = (i >= 2 && i <= 4) || (i >= 23 && i <= 25);
            ld  = (i == 0) || (i == 7) || (i == 21);
            dly = (i == 7) ? 5'd3 : 5'd8;
            cyc(1'b1, v, 8'(8'hC0 + i), i == 28, ld, dly);
            total++;
            if (pc !== 5'(ex_cnt)) begin bad++; $display("[TB] FAIL drop_count cyc=%0d got=%0d exp=%0d", i, pc, ex_cnt); end
            total++;
            if (pv !== ev_v || (ev_v && pd !== ev_d)) begin bad++; $display("[TB] FAIL drop_out cyc=%0d got=%b/%h exp=%b/%h", i, pv, pd, ev_v, ev_d); end
            total++;
            if (pdrop !== x_drop || pdly !== 5'(x_dly) || perr !== x_err) begin
                bad++; $display("[TB] FAIL drop_status cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", i, pdrop, pdly, perr, x_drop, x_dly, x_err);
            end
        end
    endtask

    task automatic test_err();
        logic [4:0] dly;
        for (int i = 0; i < 30; i++) begin
            dly = (i == 6) ? 5'd0 : ((i == 9) ? 5'd17 : 5'd5);
            cyc(1'b1, (i % 2 == 0) && i < 20, 8'(i), 1'b0, i == 0 || i == 6 || i == 9, dly);
            total++;
            if (pc !== 5'(ex_cnt)) begin bad++; $display("[TB] FAIL err_count cyc=%0d got=%0d exp=%0d", i, pc, ex_cnt); end
            total++;
            if (pv !== ev_v || (ev_v && pd !== ev_d)) begin bad++; $display("[TB] FAIL err_out cyc=%0d got=%b/%h exp=%b/%h", i, pv, pd, ev_v, ev_d); end
            total++;
            if (pdrop !== x_drop || pdly !== 5'(x_dly) || perr !== x_err) begin
                bad++; $display("[TB] FAIL err_status cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", i, pdrop, pdly, perr, x_drop, x_dly, x_err);
            end
        end
    endtask

    task automatic test_random();
        bit ce;
        bit v;
        bit fl;
        bit ld;
        for (int i = 0; i < 300; i++) begin
            ce = ($urandom % 4) != 0;
            v  = ($urandom % 2) != 0;
            fl = ($urandom % 40) == 0;
            ld = ($urandom % 30) == 0;
            cyc(ce, v, 8'($urandom), fl, ld, 5'($urandom_range(0, 17)));
            total++;
            if (pc !== 5'(ex_cnt)) begin bad++; $display("[TB] FAIL rand_count cyc=%0d got=%0d exp=%0d", i, pc, ex_cnt); end
            if (ce) begin
                total++;
                if (pv !== ev_v || (ev_v && pd !== ev_d)) begin bad++; $display("[TB] FAIL rand_out cyc=%0d got=%b/%h exp=%b/%h", i, pv, pd, ev_v, ev_d); end
            end
            total++;
            if (pdrop !== x_drop || pdly !== 5'(x_dly) || perr !== x_err) begin
                bad++; $display("[TB] FAIL rand_status cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", i, pdrop, pdly, perr, x_drop, x_dly, x_err);
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, i >= 1, 8'(8'hE0 + i), 1'b0, i == 0, 5'd5);
            total++;
            if (pc !== 5'(ex_cnt)) begin bad++; $display("[TB] FAIL mid_count cyc=%0d got=%0d exp=%0d", i, pc, ex_cnt); end
        end
        total++;
        if (q.size() != 5 || bus.oCount !== 5'd5) begin
            bad++; $display("[TB] FAIL mid_inflight got=%0d exp=5", bus.oCount);
        end
        bus.iCe = 1'b1; bus.iValid = 1'b1; bus.iData = 8'hFF;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        q.delete(); bD = 5; berr = 1'b0;
        total++;
        if (bus.oValid !== 1'b0 || bus.oData !== 8'h00 || bus.oCount !== 5'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset_stream got v=%b d=%h c=%0d exp v=0 d=00 c=0", bus.oValid, bus.oData, bus.oCount);
        end
        total++;
        if (bus.oDelay !== 5'd5 || bus.oDrop !== 1'b0 || bus.oErr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset_status got dly=%0d drop=%b err=%b exp dly=5 drop=0 err=0", bus.oDelay, bus.oDrop, bus.oErr);
        end
        aresetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
            total++;
            if (pv !== ev_v || pc !== 5'(ex_cnt)) begin
                bad++; $display("[TB] FAIL mid_stale cyc=%0d got=%b/%0d exp=%b/%0d", i, pv, pc, ev_v, ex_cnt);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_load_burst();
        test_stall();
        test_drop();
        test_err();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
